latent_sampler: RTL and testbench

Reparameterisation stage directly downstream of the final encoder layer. It accepts the two-word encoder output `y`, treating word 0 as mu and word 1 as sigma, both signed Q4.12. It generates a pseudo-Gaussian eps from an internal LFSR (sum of three uniforms, variance 1) and produces z = mu + sigma·eps with saturation, using a valid/ready handshake on both sides.

---
 rtl/latent_sampler.sv | 148 ++++++++++++++
 tb/tb_latent_sampler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/latent_sampler.sv
// latent_sampler: reparameterisation stage z = mu + sigma * eps.
// eps is pseudo-Gaussian, built as the sum of three uniforms taken from a 16-bit Galois LFSR.
// The result is saturated to the signed word range.
//
// Ports:
//   clk, reset      - single rising-edge clock, synchronous active-high reset
//   y               - {sigma, mu}, each signed Q(BITSIZE-FRAC).FRAC
//   in_valid        - y is valid
//   in_ready        - stage can accept (high only while idle)
//   eps_zero        - captured at acceptance; forces eps used in z to zero
//   z               - registered sampled latent
//   eps_out         - registered eps generated for this sample (always reported)
//   out_valid       - z / eps_out valid
//   out_ready       - consumer accepts the output
module latent_sampler #(
    parameter int unsigned BITSIZE = 16,
    parameter int unsigned FRAC    = 12,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*BITSIZE-1:0]   y,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   eps_zero,
    output logic [BITSIZE-1:0]     z,
    output logic [BITSIZE-1:0]     eps_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned PROD_W   = 2 * BITSIZE;
    localparam int unsigned SUM_W    = 2 * BITSIZE + 1;
    localparam int unsigned HI_W     = SUM_W - BITSIZE + 1;
    localparam int unsigned GEN_LAST = 2;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [BITSIZE-1:0] SAT_MAX  = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] SAT_MIN  = {1'b1, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_MUL  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                      r_state;
    logic [LFSR_W-1:0]           r_lfsr;
    logic signed [BITSIZE-1:0]   r_acc;
    logic [1:0]                  r_count;
    logic signed [BITSIZE-1:0]   r_mu;
    logic signed [BITSIZE-1:0]   r_sigma;
    logic                        r_eps_zero;

    logic [LFSR_W-1:0]           w_lfsr_next;
    logic signed [LFSR_W-1:0]    w_term;
    logic signed [BITSIZE-1:0]   w_term_ext;
    logic signed [BITSIZE-1:0]   w_sigma_eff;
    logic signed [BITSIZE-1:0]   w_eps_eff;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [PROD_W-1:0]    w_scaled;
    logic signed [SUM_W-1:0]     w_sum;
    logic [HI_W-1:0]             w_sum_hi;
    logic [BITSIZE-1:0]          w_sat;

    // Right-shifting Galois LFSR step.
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : '0);

    // Signed LFSR value divided by 8: a uniform in [-1, 1) at FRAC = 12.
    assign w_term     = $signed(r_lfsr) >>> 3;
    assign w_term_ext = BITSIZE'(w_term);

    // Negative sigma is meaningless as a standard deviation; clamp it to 0.
    assign w_sigma_eff = r_sigma[BITSIZE-1] ? '0 : r_sigma;
    assign w_eps_eff   = r_eps_zero ? '0 : r_acc;

    assign w_prod   = PROD_W'(w_sigma_eff) * PROD_W'(w_eps_eff);
    assign w_scaled = w_prod >>> FRAC;
    assign w_sum    = SUM_W'(r_mu) + SUM_W'(w_scaled);

    // The sum fits the word when the bits above the word's sign bit are all copies of it.
    assign w_sum_hi = w_sum[SUM_W-1:BITSIZE-1];
    always_comb begin
        w_sat = w_sum[BITSIZE-1:0];
        if (w_sum_hi != '0 && w_sum_hi != '1) begin
            w_sat = w_sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign in_ready = (r_state == S_IDLE);

    // Control FSM and the datapath registers it drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED_EFF;
            r_acc      <= '0;
            r_count    <= '0;
            r_mu       <= '0;
            r_sigma    <= '0;
            r_eps_zero <= 1'b0;
            z          <= '0;
            eps_out    <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mu       <= $signed(y[BITSIZE*0 +: BITSIZE]);
                        r_sigma    <= $signed(y[BITSIZE*1 +: BITSIZE]);
                        r_eps_zero <= eps_zero;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_state    <= S_GEN;
                    end
                end
                S_GEN: begin
                    // The LFSR advances every GEN cycle, even when eps is forced to zero.
                    r_acc   <= r_acc + w_term_ext;
                    r_lfsr  <= w_lfsr_next;
                    r_count <= 2'(r_count + 2'd1);
                    if (r_count == 2'(GEN_LAST)) begin
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    z         <= w_sat;
                    eps_out   <= r_acc;
                    out_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latent_sampler.sv
// Testbench for latent_sampler: directed transactions with hand-computed results.
// A scoreboard queue is filled at acceptance and drained by an output monitor.
module tb_latent_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] y;
    logic        in_valid;
    logic        in_ready;
    logic        eps_zero;
    logic [15:0] z;
    logic [15:0] eps_out;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    latent_sampler #(
        .BITSIZE(16),
        .FRAC   (12),
        .SEED   (16'hACE1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .y        (y),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .eps_zero (eps_zero),
        .z        (z),
        .eps_out  (eps_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        logic [15:0] z;
        logic [15:0] eps;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Output monitor: latency on the rising edge of out_valid, data on handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) fail_now("latency_without_expectation");
                else check("latency", 32'(cyc - q[0].acc_cyc), 32'd4);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("z", 32'(z), 32'(e.z));
                    check("eps_out", 32'(eps_out), 32'(e.eps));
                end
            end
            prev_ov <= out_valid;
        end
    end

    // Inputs are driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [15:0] mu, input logic [15:0] sigma, input logic ez,
                        input logic [15:0] exp_z, input logic [15:0] exp_eps);
        int n;
        exp_t e;
        tick();
        y        = {sigma, mu};
        eps_zero = ez;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        e.z       = exp_z;
        e.eps     = exp_eps;
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
        // Disturb inputs after acceptance; they must not be re-sampled.
        y        = ~y;
        eps_zero = ~ez;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            fail_now("drain_timeout");
            q.delete();
        end
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        y         = '0;
        in_valid  = 1'b0;
        eps_zero  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        do_reset();
        check("reset_z", 32'(z), 32'h0);
        check("reset_eps", 32'(eps_out), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);

        // eps forced to zero: z = mu, eps still reported
        send(16'h0400, 16'h1000, 1'b1, 16'h0400, 16'h0011);
        drain();

        // Normal sample then back-to-back saturating sample
        do_reset();
        send(16'h0400, 16'h1000, 1'b0, 16'h0411, 16'h0011);
        send(16'h7F00, 16'h4000, 1'b0, 16'h7FFF, 16'h0C60);
        drain();

        // Negative sigma clamps to zero
        do_reset();
        send(16'h1234, 16'hF000, 1'b0, 16'h1234, 16'h0011);
        drain();

        // Backpressure: outputs held, no acceptance, LFSR frozen
        do_reset();
        out_ready = 1'b0;
        send(16'h0400, 16'h1000, 1'b0, 16'h0411, 16'h0011);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) fail_now("stall_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            y        = $urandom;
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_z", 32'(z), 32'h0411);
            check("stall_eps", 32'(eps_out), 32'h0011);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'h0100, 16'h1000, 1'b0, 16'h0D60, 16'h0C60);
        drain();

        // Reset during the second GEN cycle aborts the transaction and reseeds
        do_reset();
        tick();
        y        = {16'h1000, 16'h0400};
        eps_zero = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_in_ready", 32'(in_ready), 32'h1);
        send(16'h0400, 16'h1000, 1'b0, 16'h0411, 16'h0011);
        drain();

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
